// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 codes, memory port codes, LSU FSM encoding
// and small decode helpers used by the LSU and by ID/EX.
// Build option: MISALIGN_TRAP_EN (misaligned H/W faults instead of being split).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam logic [1:0] MR_BYTE = 2'b00;
  localparam logic [1:0] MR_HALF = 2'b01;
  localparam logic [1:0] MR_WORD = 2'b10;

  // Encoding is fixed so the SPLIT code stays reserved in the trapping build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_SPLIT  = 3'd2,
    ST_FAULT  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Unsigned variants only exist for loads; 011/110/111 never exist.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: f3_misaligned = a[0];
      F3_W:        f3_misaligned = (a != 2'b00);
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f3_write_code(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: f3_write_code = MW_HALF;
      F3_W:        f3_write_code = MW_WORD;
      default:     f3_write_code = MW_BYTE;
    endcase
  endfunction

  function automatic logic [1:0] f3_read_code(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: f3_read_code = MR_HALF;
      F3_W:        f3_read_code = MR_WORD;
      default:     f3_read_code = MR_BYTE;
    endcase
  endfunction

  // Index of the final byte of a split access (1 for halves, 3 for words).
  function automatic logic [1:0] f3_last_byte(input logic [2:0] f3);
    f3_last_byte = (f3 == F3_W) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result extension: selects the loaded width from funct3 and sign- or
// zero-extends it to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  // Pure width/sign selection on the raw captured data.
  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_o = {24'b0, raw_i[7:0]};
      F3_HU:   ext_o = {16'b0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MEM-stage request at a time, drives the
// byte-addressed data memory, splits misaligned halves/words into byte accesses
// and returns one response pulse per request.
// Build option: MISALIGN_TRAP_EN makes misaligned H/W fault with no memory access.
// Handshake: a request is taken when req_valid & req_ready are both high at a
// rising clk edge; req_* are only sampled then. resp_valid is a one-cycle pulse
// with no backpressure and resp_fault/resp_rdata are meaningful only with it.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_write,
  output logic [1:0]        mem_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic              ready_en_q;
  logic              is_store_q, fault_q, fault_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ext_rdata;
  logic              accept;
`ifdef MISALIGN_TRAP_EN
`else
  logic [1:0]        k_q, k_d;
`endif

  assign accept    = req_valid & req_ready;
  assign dbg_state = state_q;

  // State, captured load data and the ready-enable that holds req_ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
`else
      k_q        <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
`ifdef MISALIGN_TRAP_EN
`else
      k_q        <= k_d;
`endif
    end
  end

  // Request fields are latched only at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      f3_q       <= F3_W;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      is_store_q <= req_is_store;
      f3_q       <= req_funct3;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  // Next state and memory-port drive; mem_write is nonzero only in ACCESS/SPLIT.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
`ifdef MISALIGN_TRAP_EN
`else
    k_d         = k_q;
`endif
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_write   = MW_NONE;
    mem_data    = MR_WORD;
    case (state_q)
      ST_IDLE: begin
        req_ready = ready_en_q;
        if (req_valid && ready_en_q) begin
          rdata_d = '0;
          fault_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
          if (!f3_legal(req_is_store, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0])) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
`else
          k_d = 2'd0;
          if (!f3_legal(req_is_store, req_funct3)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            state_d = ST_SPLIT;
          end else begin
            state_d = ST_ACCESS;
          end
`endif
        end
      end
      ST_ACCESS: begin
        mem_address = addr_q;
        mem_data    = f3_read_code(f3_q);
        mem_data_in = wdata_q;
        if (is_store_q) mem_write = f3_write_code(f3_q);
        else            rdata_d   = mem_rdata;
        state_d = ST_RESP;
      end
`ifdef MISALIGN_TRAP_EN
`else
      ST_SPLIT: begin
        mem_address = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
        mem_data    = MR_BYTE;
        mem_data_in = {{(DATA_W-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]};
        if (is_store_q) mem_write = MW_BYTE;
        else            rdata_d[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
        if (k_q == f3_last_byte(f3_q)) state_d = ST_RESP;
        else                           k_d     = k_q + 2'd1;
      end
`endif
      ST_FAULT: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_load_extend u_extend (
    .funct3_i (f3_q),
    .raw_i    (rdata_q),
    .ext_o    (ext_rdata)
  );

  // Response qualifiers: data only for successful loads.
  always_comb begin
    resp_fault = resp_valid & fault_q;
    resp_rdata = (resp_valid && !is_store_q && !fault_q) ? ext_rdata : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_write;
  logic [1:0]  mem_data;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data     (mem_data),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // memory model: 256 bytes, little-endian, writes on rising edge, sign-extending reads
  logic [7:0] mem [0:255];
  logic       mem_clear;
  logic [7:0] ma;
  assign ma = mem_address[7:0];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      case (mem_write)
        2'b01: mem[ma] <= mem_data_in[7:0];
        2'b10: begin
          mem[ma]       <= mem_data_in[7:0];
          mem[ma+8'd1]  <= mem_data_in[15:8];
        end
        2'b11: begin
          mem[ma]       <= mem_data_in[7:0];
          mem[ma+8'd1]  <= mem_data_in[15:8];
          mem[ma+8'd2]  <= mem_data_in[23:16];
          mem[ma+8'd3]  <= mem_data_in[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_data)
      2'b00:   mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      2'b01:   mem_rdata = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
      default: mem_rdata = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
    endcase
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    mem_word = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
  endfunction

  // driver: issue one request, follow it to its response (bounded), report what was seen
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                         output int lat, output int nw);
    int  wait_n;
    bit  got;
    bit  busy_ok;
    rd = 32'h0; flt = 1'b0; lat = -1; nw = 0; got = 0; busy_ok = 1;
    @(negedge clk);
    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout actual=%b required=1", req_ready);
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_is_store = 1'($urandom_range(0, 1));
    req_funct3   = 3'($urandom_range(0, 7));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mem_write !== 2'b00) nw++;
      if (req_ready !== 1'b0) busy_ok = 0;
      if (resp_valid === 1'b1) begin
        got = 1; lat = c; rd = resp_rdata; flt = resp_fault;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL resp_timeout addr=%h actual=none required=resp_valid", addr);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL ready_while_busy addr=%h actual=1 required=0", addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    total++;
    if ({req_ready, resp_valid, resp_fault, mem_write} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl actual=%b required=00000", {req_ready, resp_valid, resp_fault, mem_write});
    end
    total++;
    if (mem_data !== 2'b10 || mem_address !== 32'h0 || mem_data_in !== 32'h0 || resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem actual=%b/%h/%h/%h required=10/0/0/0", mem_data, mem_address, mem_data_in, resp_rdata);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge actual=%b required=0", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge actual=%b required=1", req_ready);
    end
  endtask

  task automatic test_aligned_word();
    logic [31:0] rd; logic flt; int lat, nw;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, lat, nw);
    total++;
    if (lat != 2 || nw != 1 || flt !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL sw_aligned actual=lat%0d nw%0d f%b rd%h required=lat2 nw1 f0 rd0", lat, nw, flt, rd);
    end
    total++;
    if (mem_word(8'h10) !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL sw_aligned_mem actual=%h required=deadbeef", mem_word(8'h10));
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat, nw);
    total++;
    if (lat != 2 || nw != 0 || flt !== 1'b0 || rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_aligned actual=lat%0d nw%0d f%b rd%h required=lat2 nw0 f0 rd=deadbeef", lat, nw, flt, rd);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic flt; int lat, nw;
    logic [2:0]  f3_tab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad_tab [4] = '{32'h21, 32'h21, 32'h20, 32'h20};
    run_req(1'b1, 3'b000, 32'h21, 32'h80, rd, flt, lat, nw);
    total++;
    if (lat != 2 || nw != 1 || mem[8'h21] !== 8'h80 || mem[8'h20] !== 8'h00 || mem[8'h22] !== 8'h00) begin
      bad++;
      $display("FAIL sb_0x21 actual=lat%0d nw%0d m%h/%h/%h required=lat2 nw1 00/80/00", lat, nw, mem[8'h20], mem[8'h21], mem[8'h22]);
    end
    exp_q = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3_tab[i], ad_tab[i], 32'h0, rd, flt, lat, nw);
      total++;
      if (rd !== exp_q[i] || lat != 2 || flt !== 1'b0) begin
        bad++;
        $display("FAIL load_ext f3=%b actual=%h lat%0d required=%h lat2", f3_tab[i], rd, lat, exp_q[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic flt; int lat, nw;
    run_req(1'b1, 3'b010, 32'h13, 32'h11223344, rd, flt, lat, nw);
`ifdef MISALIGN_TRAP_EN
    total++;
    if (lat != 2 || nw != 0 || flt !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL sw_trap actual=lat%0d nw%0d f%b rd%h required=lat2 nw0 f1 rd0", lat, nw, flt, rd);
    end
    total++;
    if (mem_word(8'h10) !== 32'hDEADBEEF || mem_word(8'h14) !== 32'h0) begin
      bad++;
      $display("FAIL sw_trap_mem actual=%h/%h required=deadbeef/0", mem_word(8'h10), mem_word(8'h14));
    end
`else
    total++;
    if (lat != 5 || nw != 4 || flt !== 1'b0) begin
      bad++;
      $display("FAIL sw_split actual=lat%0d nw%0d f%b required=lat5 nw4 f0", lat, nw, flt);
    end
    total++;
    if (mem_word(8'h10) !== 32'h44ADBEEF || mem_word(8'h14) !== 32'h00112233) begin
      bad++;
      $display("FAIL sw_split_mem actual=%h/%h required=44adbeef/00112233", mem_word(8'h10), mem_word(8'h14));
    end
    run_req(1'b0, 3'b010, 32'h13, 32'h0, rd, flt, lat, nw);
    total++;
    if (lat != 5 || nw != 0 || rd !== 32'h11223344) begin
      bad++;
      $display("FAIL lw_split actual=lat%0d nw%0d rd%h required=lat5 nw0 rd=11223344", lat, nw, rd);
    end
    run_req(1'b0, 3'b001, 32'h15, 32'h0, rd, flt, lat, nw);
    total++;
    if (lat != 3 || rd !== 32'h00001122) begin
      bad++;
      $display("FAIL lh_split actual=lat%0d rd%h required=lat3 rd=00001122", lat, rd);
    end
    run_req(1'b0, 3'b001, 32'h21, 32'h0, rd, flt, lat, nw);
    total++;
    if (lat != 3 || rd !== 32'h00000080) begin
      bad++;
      $display("FAIL lh_split_pos actual=lat%0d rd%h required=lat3 rd=00000080", lat, rd);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic flt; int lat, nw;
    run_req(1'b0, 3'b011, 32'h10, 32'h0, rd, flt, lat, nw);
    total++;
    if (lat != 2 || nw != 0 || flt !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL load_f3_011 actual=lat%0d nw%0d f%b rd%h required=lat2 nw0 f1 rd0", lat, nw, flt, rd);
    end
    run_req(1'b1, 3'b100, 32'h40, 32'h55, rd, flt, lat, nw);
    total++;
    if (lat != 2 || nw != 0 || flt !== 1'b1 || mem[8'h40] !== 8'h00) begin
      bad++;
      $display("FAIL store_f3_100 actual=lat%0d nw%0d f%b m%h required=lat2 nw0 f1 m00", lat, nw, flt, mem[8'h40]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt; int lat, nw;
    run_req(1'b1, 3'b000, 32'h50, 32'hFFFFFF12, rd, flt, lat, nw);
    run_req(1'b1, 3'b000, 32'h51, 32'h00000034, rd, flt, lat, nw);
    run_req(1'b0, 3'b101, 32'h50, 32'h0, rd, flt, lat, nw);
    total++;
    if (rd !== 32'h00003412 || lat != 2 || mem[8'h52] !== 8'h00) begin
      bad++;
      $display("FAIL b2b_lhu actual=%h lat%0d m52=%h required=00003412 lat2 m52=00", rd, lat, mem[8'h52]);
    end
  endtask

  task automatic test_reset_split();
`ifdef MISALIGN_TRAP_EN
`else
    bit saw_resp;
    int wait_n;
    saw_resp = 0;
    @(negedge clk);
    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h31; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 2'b00 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_abort actual=mw%b st%0d required=mw00 st0", mem_write, dbg_state);
    end
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) saw_resp = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) saw_resp = 1;
    end
    total++;
    if (saw_resp) begin
      bad++;
      $display("FAIL reset_no_resp actual=resp_valid required=none");
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_back actual=%b required=1", req_ready);
    end
    total++;
    if (mem[8'h31] !== 8'hD4 || mem[8'h32] !== 8'h00 || mem[8'h33] !== 8'h00 || mem[8'h34] !== 8'h00) begin
      bad++;
      $display("FAIL reset_split_mem actual=%h %h %h %h required=d4 00 00 00", mem[8'h31], mem[8'h32], mem[8'h33], mem[8'h34]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_byte_half();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_split();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
